// File: rtl/sad_sequencer.sv
// Full-search SAD pass controller: loads the 4-row window, streams frame column pairs
// through the datapath and keeps the running minimum SAD with its position.
module sad_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] window_base,
    input  logic [15:0]       row_stride,
    input  logic [DIM_W-1:0]  frame_rows,
    input  logic [DIM_W-1:0]  frame_cols,
    output logic [ADDR_W-1:0] MEM_SAD_Address_A,
    output logic [ADDR_W-1:0] MEM_SAD_Address_B,
    output logic              frame_shift,
    output logic              window_shift,
    input  logic [9:0]        KA1,
    input  logic [9:0]        KA2,
    input  logic [9:0]        KA3,
    input  logic [9:0]        KA4,
    input  logic [9:0]        KB1,
    input  logic [9:0]        KB2,
    input  logic [9:0]        KB3,
    input  logic [9:0]        KB4,
    output logic              busy,
    output logic              done,
    output logic [11:0]       min_sad,
    output logic [DIM_W-1:0]  min_row,
    output logic [DIM_W-1:0]  min_col
);

    localparam int unsigned SAD_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WIN,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q,    state_d;
    logic [1:0]        win_cnt_q,  win_cnt_d;
    logic [DIM_W-1:0]  row_q,      row_d;
    logic [DIM_W-1:0]  pair_q,     pair_d;
    logic [DIM_W-1:0]  rows_q,     rows_d;
    logic [DIM_W-1:0]  pairs_q,    pairs_d;
    logic [ADDR_W-1:0] stride_q,   stride_d;
    logic [ADDR_W-1:0] col_base_q, col_base_d;
    logic [ADDR_W-1:0] addr_a_q,   addr_a_d;
    logic [ADDR_W-1:0] addr_b_q,   addr_b_d;
    logic              wshift_q,   wshift_d;
    logic              fshift_q,   fshift_d;
    logic [DIM_W-1:0]  vrow_q,     vrow_d;
    logic [DIM_W-1:0]  vpair_q,    vpair_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [SAD_W-1:0]  min_sad_q,  min_sad_d;
    logic [DIM_W-1:0]  min_row_q,  min_row_d;
    logic [DIM_W-1:0]  min_col_q,  min_col_d;

    logic [SAD_W-1:0]  sad_a_c;
    logic [SAD_W-1:0]  sad_b_c;
    logic [ADDR_W-1:0] stride_in_c;
    logic              cand_c;

    assign sad_a_c     = SAD_W'(KA1) + SAD_W'(KA2) + SAD_W'(KA3) + SAD_W'(KA4);
    assign sad_b_c     = SAD_W'(KB1) + SAD_W'(KB2) + SAD_W'(KB3) + SAD_W'(KB4);
    assign stride_in_c = ADDR_W'(row_stride);
    // Data returning for row r completes the candidate whose top row is r-3.
    assign cand_c      = fshift_q && (vrow_q >= DIM_W'(3));

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        row_d      = row_q;
        pair_d     = pair_q;
        rows_d     = rows_q;
        pairs_d    = pairs_q;
        stride_d   = stride_q;
        col_base_d = col_base_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        wshift_d   = 1'b0;
        fshift_d   = 1'b0;
        vrow_d     = vrow_q;
        vpair_d    = vpair_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        min_sad_d  = min_sad_q;
        min_row_d  = min_row_q;
        min_col_d  = min_col_q;

        // A is tested before B so that A wins ties within a cycle.
        if (cand_c) begin
            if (sad_a_c < min_sad_d) begin
                min_sad_d = sad_a_c;
                min_row_d = vrow_q - DIM_W'(3);
                min_col_d = vpair_q << 1;
            end
            if (sad_b_c < min_sad_d) begin
                min_sad_d = sad_b_c;
                min_row_d = vrow_q - DIM_W'(3);
                min_col_d = (vpair_q << 1) | DIM_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD_WIN;
                    busy_d     = 1'b1;
                    win_cnt_d  = 2'd0;
                    row_d      = '0;
                    pair_d     = '0;
                    rows_d     = frame_rows;
                    pairs_d    = frame_cols >> 1;
                    stride_d   = stride_in_c;
                    col_base_d = frame_base;
                    addr_a_d   = window_base + (stride_in_c << 1) + stride_in_c;
                    addr_b_d   = '0;
                    vrow_d     = '0;
                    vpair_d    = '0;
                    min_sad_d  = '1;
                    min_row_d  = '0;
                    min_col_d  = '0;
                end
            end
            S_LOAD_WIN: begin
                wshift_d = 1'b1;
                if (win_cnt_q == 2'd3) begin
                    if ((pairs_q == '0) || (rows_q == '0)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d  = S_SCAN;
                        addr_a_d = col_base_q;
                        addr_b_d = col_base_q + ADDR_W'(1);
                    end
                end else begin
                    win_cnt_d = win_cnt_q + 2'd1;
                    addr_a_d  = addr_a_q - stride_q;
                end
            end
            S_SCAN: begin
                fshift_d = 1'b1;
                vrow_d   = row_q;
                vpair_d  = pair_q;
                if (row_q == rows_q - DIM_W'(1)) begin
                    if (pair_q == pairs_q - DIM_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        pair_d     = pair_q + DIM_W'(1);
                        row_d      = '0;
                        col_base_d = col_base_q + ADDR_W'(2);
                        addr_a_d   = col_base_q + ADDR_W'(2);
                        addr_b_d   = col_base_q + ADDR_W'(3);
                    end
                end else begin
                    row_d    = row_q + DIM_W'(1);
                    addr_a_d = addr_a_q + stride_q;
                    addr_b_d = addr_b_q + stride_q;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            win_cnt_q  <= '0;
            row_q      <= '0;
            pair_q     <= '0;
            rows_q     <= '0;
            pairs_q    <= '0;
            stride_q   <= '0;
            col_base_q <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            wshift_q   <= 1'b0;
            fshift_q   <= 1'b0;
            vrow_q     <= '0;
            vpair_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            min_sad_q  <= '1;
            min_row_q  <= '0;
            min_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            row_q      <= row_d;
            pair_q     <= pair_d;
            rows_q     <= rows_d;
            pairs_q    <= pairs_d;
            stride_q   <= stride_d;
            col_base_q <= col_base_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            wshift_q   <= wshift_d;
            fshift_q   <= fshift_d;
            vrow_q     <= vrow_d;
            vpair_q    <= vpair_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            min_sad_q  <= min_sad_d;
            min_row_q  <= min_row_d;
            min_col_q  <= min_col_d;
        end
    end

    assign MEM_SAD_Address_A = addr_a_q;
    assign MEM_SAD_Address_B = addr_b_q;
    assign window_shift      = wshift_q;
    assign frame_shift       = fshift_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign min_sad           = min_sad_q;
    assign min_row           = min_row_q;
    assign min_col           = min_col_q;

endmodule

// File: tb/tb_sad_sequencer.sv
// Bench for sad_sequencer: emulates SAD memory and datapath, scoreboards each pass
// against a search computed directly over the frame and window arrays.
module tb_sad_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DIM_W  = 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              start;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] window_base;
    logic [15:0]       row_stride;
    logic [DIM_W-1:0]  frame_rows;
    logic [DIM_W-1:0]  frame_cols;
    logic [ADDR_W-1:0] MEM_SAD_Address_A;
    logic [ADDR_W-1:0] MEM_SAD_Address_B;
    logic              frame_shift;
    logic              window_shift;
    logic [9:0]        KA1, KA2, KA3, KA4, KB1, KB2, KB3, KB4;
    logic              busy;
    logic              done;
    logic [11:0]       min_sad;
    logic [DIM_W-1:0]  min_row;
    logic [DIM_W-1:0]  min_col;

    sad_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .frame_base(frame_base), .window_base(window_base), .row_stride(row_stride),
        .frame_rows(frame_rows), .frame_cols(frame_cols),
        .MEM_SAD_Address_A(MEM_SAD_Address_A), .MEM_SAD_Address_B(MEM_SAD_Address_B),
        .frame_shift(frame_shift), .window_shift(window_shift),
        .KA1(KA1), .KA2(KA2), .KA3(KA3), .KA4(KA4),
        .KB1(KB1), .KB2(KB2), .KB3(KB3), .KB4(KB4),
        .busy(busy), .done(done),
        .min_sad(min_sad), .min_row(min_row), .min_col(min_col)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int sad;
        int row;
        int col;
        int n;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          chk_b;
    } addr_t;

    exp_t  exp_q[$];
    addr_t addr_q[$];

    int errors = 0;
    int checks = 0;
    int rst_chk_req = 0;
    int rst_chk_seen = 0;

    logic [31:0] mem [0:4095];

    function automatic int sad4(input logic [31:0] x, input logic [31:0] y);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            int a = int'(x[8*i +: 8]);
            int b = int'(y[8*i +: 8]);
            s += (a > b) ? (a - b) : (b - a);
        end
        return s;
    endfunction

    // Memory with one-cycle read latency plus the window / frame shift registers.
    logic [31:0] rd_a = '0, rd_b = '0;
    logic [31:0] win [0:3] = '{default: '0};
    logic [31:0] fra [0:2] = '{default: '0};
    logic [31:0] frb [0:2] = '{default: '0};

    always @(posedge Clk) begin
        rd_a <= mem[MEM_SAD_Address_A[11:0]];
        rd_b <= mem[MEM_SAD_Address_B[11:0]];
        if (window_shift) begin
            win[0] <= win[1]; win[1] <= win[2]; win[2] <= win[3]; win[3] <= rd_a;
        end
        if (frame_shift) begin
            fra[0] <= fra[1]; fra[1] <= fra[2]; fra[2] <= rd_a;
            frb[0] <= frb[1]; frb[1] <= frb[2]; frb[2] <= rd_b;
        end
    end

    // win[0] holds window row 3, matched with the live frame word.
    assign KA1 = 10'(sad4(rd_a,   win[0]));
    assign KA2 = 10'(sad4(fra[2], win[1]));
    assign KA3 = 10'(sad4(fra[1], win[2]));
    assign KA4 = 10'(sad4(fra[0], win[3]));
    assign KB1 = 10'(sad4(rd_b,   win[0]));
    assign KB2 = 10'(sad4(frb[2], win[1]));
    assign KB3 = 10'(sad4(frb[1], win[2]));
    assign KB4 = 10'(sad4(frb[0], win[3]));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exhaustive search in candidate time order (pair, top row, A then B).
    task automatic push_expect(input int fb, input int wb, input int st, input int rows, input int cols);
        int np = cols / 2;
        int best = 4095;
        int br = 0;
        int bc = 0;
        addr_t e;
        for (int k = 0; k < 4; k++) begin
            e.a = 32'(wb + (3 - k) * st); e.b = '0; e.chk_b = 1'b0;
            addr_q.push_back(e);
        end
        for (int p = 0; p < np; p++) begin
            for (int r = 0; r < rows; r++) begin
                e.a = 32'(fb + r * st + 2 * p); e.b = 32'(fb + r * st + 2 * p + 1); e.chk_b = 1'b1;
                addr_q.push_back(e);
            end
        end
        for (int p = 0; p < np; p++) begin
            for (int t = 0; t + 3 < rows; t++) begin
                for (int side = 0; side < 2; side++) begin
                    int c = 2 * p + side;
                    int s = 0;
                    for (int i = 0; i < 4; i++)
                        s += sad4(mem[(fb + (t + i) * st + c) & 4095], mem[(wb + i * st) & 4095]);
                    if (s < best) begin
                        best = s; br = t; bc = c;
                    end
                end
            end
        end
        exp_q.push_back('{sad: best, row: br, col: bc, n: np * rows});
    endtask

    task automatic set_params(input int fb, input int wb, input int st, input int rows, input int cols);
        frame_base  = 32'(fb);
        window_base = 32'(wb);
        row_stride  = 16'(st);
        frame_rows  = 8'(rows);
        frame_cols  = 8'(cols);
    endtask

    // Called at posedge+1 while the DUT is idle; start is accepted on the next edge.
    task automatic start_pass(input int fb, input int wb, input int st, input int rows, input int cols);
        set_params(fb, wb, st, rows, cols);
        push_expect(fb, wb, st, rows, cols);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge Clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            $display("FAIL wait_done timeout after %0d cycles", budget);
            $fatal(1, "pass did not complete");
        end
        @(posedge Clk); #1;
    endtask

    task automatic fill_word(input int fb, input int st, input int r, input int c, input logic [31:0] v);
        mem[(fb + r * st + c) & 4095] = v;
    endtask

    // Monitor: per-pass address trace, strobe counts, latency and final minimum.
    bit   in_pass = 1'b0;
    int   cyc = 0, ws = 0, fs = 0;
    exp_t cur;
    addr_t ea;

    always @(negedge Clk) begin
        if (rst_chk_req != rst_chk_seen) begin
            rst_chk_seen = rst_chk_req;
            chk("rst_busy", longint'(busy), 0);
            chk("rst_done", longint'(done), 0);
            chk("rst_wshift", longint'(window_shift), 0);
            chk("rst_fshift", longint'(frame_shift), 0);
            chk("rst_addr_a", longint'(MEM_SAD_Address_A), 0);
            chk("rst_addr_b", longint'(MEM_SAD_Address_B), 0);
            chk("rst_min_sad", longint'(min_sad), 4095);
            chk("rst_min_row", longint'(min_row), 0);
            chk("rst_min_col", longint'(min_col), 0);
        end
        if (Reset) begin
            in_pass = 1'b0;
            exp_q.delete();
            addr_q.delete();
        end else begin
            if (busy && !in_pass) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pass busy=1 with no pass expected at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    in_pass = 1'b1;
                    cyc = 0; ws = 0; fs = 0;
                end
            end
            if (in_pass) begin
                if (window_shift) ws++;
                if (frame_shift) fs++;
                if (cyc < 4 + cur.n) begin
                    if (addr_q.size() == 0) begin
                        chk("addr_queue_empty", 1, 0);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("addr_a", longint'(MEM_SAD_Address_A), longint'(ea.a));
                        if (ea.chk_b) chk("addr_b", longint'(MEM_SAD_Address_B), longint'(ea.b));
                    end
                end
                if (done) begin
                    chk("done_latency", cyc, 5 + cur.n);
                    chk("window_shift_count", ws, 4);
                    chk("frame_shift_count", fs, cur.n);
                    chk("min_sad", longint'(min_sad), cur.sad);
                    chk("min_row", longint'(min_row), cur.row);
                    chk("min_col", longint'(min_col), cur.col);
                    in_pass = 1'b0;
                end else if (cyc > 9 + cur.n) begin
                    chk("pass_timeout", cyc, 5 + cur.n);
                    in_pass = 1'b0;
                end
                cyc++;
            end else begin
                chk("idle_strobes", longint'({window_shift, frame_shift}), 0);
                chk("idle_done", longint'(done), 0);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        set_params(0, 0, 0, 0, 0);
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(posedge Clk);
        #1 rst_chk_req++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Single exact-match spot at column 3, rows 2..5.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++)
                fill_word(0, 16, r, c, (c == 3 && r >= 2 && r <= 5) ? 32'h10101010 : 32'h20202020);
        for (int i = 0; i < 4; i++) fill_word(2048, 16, i, 0, 32'h10101010);
        start_pass(0, 2048, 16, 8, 4);
        wait_done(50);

        // Uniform frame: all candidates tie at 16, first one must be kept.
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 2; c++) fill_word(0, 16, r, c, 32'h11111111);
        start_pass(0, 2048, 16, 6, 2);
        wait_done(40);

        // Address sequence with window at 100.
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        start_pass(0, 100, 16, 4, 4);
        wait_done(40);

        // Degenerate sizes.
        start_pass(0, 2048, 16, 3, 4);
        wait_done(40);
        start_pass(0, 2048, 16, 5, 1);
        wait_done(40);
        start_pass(0, 2048, 16, 0, 4);
        wait_done(40);

        // Reset ten cycles into a pass, then a clean pass.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        start_pass(0, 2048, 16, 8, 4);
        repeat (9) begin @(posedge Clk); #1; end
        Reset = 1'b1;
        @(posedge Clk); #1;
        rst_chk_req++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        start_pass(0, 2048, 16, 8, 4);
        wait_done(50);

        // start held high across a pass: exactly two back-to-back passes.
        set_params(4, 2060, 20, 5, 5);
        push_expect(4, 2060, 20, 5, 5);
        push_expect(4, 2060, 20, 5, 5);
        start = 1'b1;
        wait_done(50);
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done(50);
        repeat (4) begin @(posedge Clk); #1; end

        // start pulsed while busy must be ignored.
        start_pass(8, 2048, 24, 6, 6);
        repeat (4) begin @(posedge Clk); #1; end
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done(50);
        repeat (4) begin @(posedge Clk); #1; end

        // Randomized passes.
        for (int t = 0; t < 24; t++) begin
            int fb, wb, st, rows, cols;
            for (int i = 0; i < 512; i++) mem[i] = $urandom;
            for (int i = 2048; i < 2304; i++) mem[i] = (t % 3 == 0) ? (mem[i % 512] ^ 32'h01010101) : $urandom;
            fb   = int'($urandom_range(0, 200));
            wb   = 2048 + int'($urandom_range(0, 100));
            st   = int'($urandom_range(16, 32));
            rows = int'($urandom_range(0, 10));
            cols = int'($urandom_range(0, 9));
            start_pass(fb, wb, st, rows, cols);
            wait_done(80);
            repeat (int'($urandom_range(0, 2))) begin @(posedge Clk); #1; end
        end

        repeat (5) @(posedge Clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_passes actual=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
